// File: rtl/decoder_scan_pkg.sv
// Shared types and constants for the decoder scan sequencer.
// Imported by the top level and the dwell counter.
package decoder_scan_pkg;

   localparam int ADDR_W    = 3;
   localparam int BLANK_CYC = 2;

   typedef enum logic [2:0] {
      IDLE,
      ON,
      BLK_HOLD,
      BLK_ADV,
      DONE
   } scan_state_t;

endpackage

// File: rtl/decoder_3_to_8.sv
// Downstream 3-to-8 one-hot decoder driven by the scan sequencer.
// Output is all-zero while the enable is low.
module decoder_3_to_8 (
   input  logic       en,
   input  logic [2:0] a,
   output logic [7:0] out
);

   always_comb begin
      out = 8'h00;
      if (en) out = 8'h01 << a;
   end

endmodule

// File: rtl/decoder_scan_sequencer_dwell_counter.sv
// Dwell timer: pulses expire on the limit-th cycle after load.
// A limit of zero behaves as one.
module dwell_counter #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [DWELL_W-1:0] limit,
   output logic               expire
);

   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [DWELL_W-1:0] lim_q, lim_d;
   logic               run_q, run_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
         lim_q <= '0;
         run_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         lim_q <= lim_d;
         run_q <= run_d;
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      lim_d  = lim_q;
      run_d  = run_q;
      expire = run_q && (cnt_q == lim_q);
      if (load) begin
         cnt_d = DWELL_W'(1);
         lim_d = (limit == '0) ? DWELL_W'(1) : limit;
         run_d = 1'b1;
      end else if (expire) begin
         run_d = 1'b0;
      end else if (run_q) begin
         cnt_d = cnt_q + DWELL_W'(1);
      end
   end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Scans a circular address range into a 3-to-8 decoder with
// glitch-free blanking between addresses and a programmable dwell.
module decoder_scan_sequencer
   import decoder_scan_pkg::*;
#(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic [2:0]         first,
   input  logic [2:0]         last,
   input  logic [DWELL_W-1:0] dwell,
   output logic               en,
   output logic [2:0]         a,
   output logic               busy,
   output logic               done,
   output logic               aborted
);

   scan_state_t        state_q, state_d;
   logic [ADDR_W-1:0]  a_q, a_d;
   logic [ADDR_W-1:0]  last_q, last_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic               en_q, en_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               abort_q, abort_d;
   logic               load;
   logic               expire;
   logic [DWELL_W-1:0] limit;

   // The first address uses the live dwell input, later ones the latched copy.
   assign limit = (state_q == IDLE) ? dwell : dwell_q;

   dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load),
      .limit  (limit),
      .expire (expire)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         last_q  <= '0;
         dwell_q <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         last_q  <= last_d;
         dwell_q <= dwell_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         abort_q <= abort_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      last_d  = last_q;
      dwell_d = dwell_q;
      en_d    = en_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      abort_d = 1'b0;
      load    = 1'b0;
      if (state_q != IDLE && stop) begin
         state_d = IDLE;
         en_d    = 1'b0;
         busy_d  = 1'b0;
         abort_d = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               en_d   = 1'b0;
               busy_d = 1'b0;
               if (start && !stop) begin
                  last_d  = last;
                  dwell_d = dwell;
                  a_d     = first;
                  en_d    = 1'b1;
                  busy_d  = 1'b1;
                  load    = 1'b1;
                  state_d = ON;
               end
            end
            ON: begin
               if (expire) begin
                  en_d = 1'b0;
                  if (a_q == last_q) begin
                     done_d  = 1'b1;
                     state_d = DONE;
                  end else begin
                     state_d = BLK_HOLD;
                  end
               end
            end
            BLK_HOLD: begin
               a_d     = a_q + 3'd1;
               state_d = BLK_ADV;
            end
            BLK_ADV: begin
               en_d    = 1'b1;
               load    = 1'b1;
               state_d = ON;
            end
            DONE: begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign en      = en_q;
   assign a       = a_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign aborted = abort_q;

endmodule

// File: doc/decoder_scan_sequencer.md
# decoder_scan_sequencer

Synchronous sequencer that drives the `en` and `a[2:0]` inputs of the `decoder_3_to_8` stage directly downstream. It steps the select address through a programmable circular range, holding each address enabled for a programmable dwell time. The enable is dropped around every address change so the decoder output never glitches between one-hot codes. Typical use: row/column scanning, such as LED matrix rows or multiplexed strobes.

## Interface
- `DWELL_W`, 8, width of the dwell-time input.
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: begin a scan; sampled only in IDLE.
- `stop` in 1: abort the current scan; has priority over `start`.
- `first` in 3: first address of the range; latched on accepted `start`.
- `last` in 3: last address of the range; latched on accepted `start`.
- `dwell` in DWELL_W: number of cycles each address is enabled; latched on accepted `start`; 0 is treated as 1.
- `en` out 1: decoder enable; registered.
- `a` out 3: decoder address; registered.
- `busy` out 1: high from the cycle after an accepted `start` through the DONE cycle.
- `done` out 1: one-cycle pulse after the final address completes.
- `aborted` out 1: one-cycle pulse after `stop` ends a scan.

## Operation
- **States:** IDLE, ON, BLK_HOLD, BLK_ADV, DONE.
- **IDLE**
  - `en`=0, `busy`=0, and `a` holds its last value.
  - `start`=1 with `stop`=0: latch `first`, `last` and `dwell`; load `a`=`first`; set `en`=1; go to ON.
- **ON**
  - `en`=1 and the dwell counter counts up to max(`dwell`,1).
  - On expiry with `a`==`last_q`: go to DONE.
  - On expiry otherwise: go to BLK_HOLD.
- **BLK_HOLD**
  - `en`=0 and `a` is unchanged.
  - Next state is BLK_ADV, where `a` is loaded with (`a`+1) mod 8.
- **BLK_ADV**
  - `en`=0 and `a` holds the new value.
  - Next state is ON, with `en` returning to 1.
- **DONE**
  - `en`=0, `done`=1, `busy`=1 for one cycle, then IDLE.
- **Address-change invariant:** `a` may change only on a clock edge where `en` is 0 both before and after that edge. The single exception is the IDLE→ON edge, where `a` loads `first` while `en` rises.
- **Range length** K = ((`last`−`first`) mod 8)+1, giving 1..8 addresses.
  - The scan wraps from 7 to 0 when `last` < `first`.
  - `first`==`last` produces a single-address scan.
  - `last`==(`first`−1) mod 8 produces a full 8-address scan.
- **stop:** in any state other than IDLE, the next edge goes to IDLE with `en`=0, `a` holding its value, `aborted`=1 for one cycle and no `done`.
- **Ignored inputs:**
  - `start` while not in IDLE.
  - Changes to `first`, `last` or `dwell` during a scan.
- **Reset:** while `rst_n`=0 at an edge, including mid-scan, the block clears to `en`=0, `a`=0, `busy`=0, `done`=0, `aborted`=0 and state IDLE.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- **Start latency:** `start` sampled at edge 0 gives `en`=1, `a`=`first` and `busy`=1 from cycle 1.
- **Dwell:** each address has `en` high for exactly D=max(`dwell`,1) consecutive cycles.
- **Gap:** `en` is low for exactly 2 cycles between consecutive addresses.
- **Scan length:** with K addresses, `done` is high in cycle K·D+2(K−1)+1, and `busy` falls in the following cycle.
- **Back-to-back scans:** a new `start` is accepted in the cycle `busy`=0 (the first IDLE cycle), so there is at least a one-cycle IDLE gap between scans.
- **Stop latency:** `stop` sampled at edge n gives `en`=0 and `aborted`=1 in cycle n+1, and `busy`=0 in cycle n+1.

## Structure
- **Package `decoder_scan_pkg`:**
  - state enum `scan_state_t` (IDLE, ON, BLK_HOLD, BLK_ADV, DONE);
  - constant `ADDR_W`=3;
  - constant `BLANK_CYC`=2.
- **Sub-module `dwell_counter`** (parameter DWELL_W):
  - inputs `clk`, `rst_n`, `load`, `limit`;
  - output `expire`, a one-cycle pulse on the limit-th cycle after `load`;
  - treats `limit`=0 as 1.
- The top level holds the FSM, the latched range registers and the address register.
- Every bench instantiates `decoder_3_to_8` downstream and checks that its `out` is never non-zero for an address other than the current one.

## Test plan
- **Basic scan:** reset, then `start` with `first`=0, `last`=2, `dwell`=2.
  - `en` high in cycles 1–2, 5–6 and 9–10 with `a`=0, 1, 2 respectively.
  - `done` in cycle 11.
  - Decoder `out` sequence 0x01, 0x02, 0x04, with 0x00 between.
- **Wrap and full range:** `first`=6, `last`=1, `dwell`=1 gives `a` sequence 6, 7, 0, 1 with `done` in cycle 11. `first`=3, `last`=2 steps through all 8 addresses and gives `done` in cycle 23.
- **Single address and zero dwell:** `first`=`last`=5, `dwell`=0 gives `en` high in cycle 1 only with `a`=5, and `done` in cycle 2.
- **Abort:** `start` with `dwell`=4, then `stop` in the 3rd cycle of the second address.
  - Next cycle: `en`=0, `aborted`=1, `busy`=0, `a` still 1.
  - No `done` pulse.
  - `start` and `stop` together in IDLE leave the block in IDLE.
- **Ignored inputs:** `start` re-asserted while busy, and `dwell`/`last` changed mid-scan, leave the sequence identical to the basic scan.
- **Reset mid-scan:** `rst_n`=0 for one edge during ON.
  - Next cycle: `en`=0, `a`=0, all pulses 0.
  - A subsequent `start` scans normally.
- **Invariant check throughout all scenarios:** `a` never changes on an edge where `en` is 1 on either side, except the IDLE→ON load.
